// File: rtl/pipe_pkg.sv
// Shared types and helpers for the IF/ID pipeline register.
package pipe_pkg;

    // Field widths of the default configuration.
    localparam int DEF_REG_W     = 3;
    localparam int DEF_IMM_OUT_W = 3;
    localparam int DEF_PCW       = 8;

    // One decoded IF/ID entry in the default configuration.
    typedef struct packed {
        logic [DEF_REG_W-1:0]     rs1;
        logic [DEF_REG_W-1:0]     rs2;
        logic [DEF_REG_W-1:0]     rd;
        logic [DEF_IMM_OUT_W-1:0] imm;
        logic [DEF_PCW-1:0]       pc;
        logic                     regwrite;
        logic                     wbsel;
    } if_id_entry_t;

    // The zero bubble: invalid slot, nothing written back.
    localparam if_id_entry_t IF_ID_BUBBLE = '0;

    // Right-aligns the field that starts at bit lsb.
    // The caller truncates the result to the field width.
    function automatic logic [63:0] slice_field(input logic [63:0] word,
                                                input int unsigned lsb);
        return word >> lsb;
    endfunction

endpackage

// File: rtl/if_id_skid.sv
// Two-entry skid buffer: a main entry that drives the outputs and an
// internal skid entry that absorbs one instruction while decode stalls.
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high; in_ready is registered and never depends on out_ready.
module if_id_skid
    import pipe_pkg::*;
#(
    parameter type entry_t = if_id_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    localparam entry_t BUBBLE = '0;

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_data_q,  main_data_d;
    entry_t skid_data_q,  skid_data_d;
    logic   accept;
    logic   pop;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign accept    = in_valid & ~skid_valid_q;
    assign pop       = main_valid_q & out_ready;

    // Next-state of both entries; flush beats every other transition.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (!main_valid_q) begin
            // Skid is never occupied while main is empty.
            main_valid_d = accept;
            main_data_d  = accept ? in_data : BUBBLE;
        end else if (pop) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = BUBBLE;
            end else if (accept) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = BUBBLE;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Entry registers with synchronous reset to the empty state.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: decodes register and immediate fields at
// capture, buffers through a two-entry skid and counts useful flushes.
module if_id_pipe
    import pipe_pkg::*;
#(
    parameter int IW         = 8,
    parameter int PCW        = 8,
    parameter int REG_W      = 3,
    parameter int RS1_LSB    = 3,
    parameter int RS2_LSB    = 0,
    parameter int RD_LSB     = 3,
    parameter int IMM_LSB    = 0,
    parameter int IMM_W      = 3,
    parameter int IMM_OUT_W  = 3,
    parameter int IMM_SIGNED = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        instrcode,
    input  logic [PCW-1:0]       pc_in,
    input  logic                 regwrite,
    input  logic                 wbsel,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_W-1:0]     read_reg1,
    output logic [REG_W-1:0]     read_reg2,
    output logic [REG_W-1:0]     write_reg,
    output logic [IMM_OUT_W-1:0] immdata,
    output logic                 regwriteout,
    output logic                 wbsel_out,
    output logic [PCW-1:0]       pc_out,
    output logic [CNT_W-1:0]     flush_count
);

    typedef struct packed {
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [REG_W-1:0]     rd;
        logic [IMM_OUT_W-1:0] imm;
        logic [PCW-1:0]       pc;
        logic                 regwrite;
        logic                 wbsel;
    } entry_t;

    entry_t           in_entry;
    entry_t           main_entry;
    logic [IMM_W-1:0] imm_raw;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Slice and extend the incoming instruction into an entry.
    always_comb begin
        imm_raw           = IMM_W'(slice_field(64'(instrcode), IMM_LSB));
        in_entry          = '0;
        in_entry.rs1      = REG_W'(slice_field(64'(instrcode), RS1_LSB));
        in_entry.rs2      = REG_W'(slice_field(64'(instrcode), RS2_LSB));
        in_entry.rd       = REG_W'(slice_field(64'(instrcode), RD_LSB));
        if (IMM_SIGNED != 0) begin
            in_entry.imm  = IMM_OUT_W'(signed'(imm_raw));
        end else begin
            in_entry.imm  = IMM_OUT_W'(imm_raw);
        end
        in_entry.pc       = pc_in;
        in_entry.regwrite = regwrite;
        in_entry.wbsel    = wbsel;
    end

    if_id_skid #(
        .entry_t (entry_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_entry)
    );

    assign read_reg1   = main_entry.rs1;
    assign read_reg2   = main_entry.rs2;
    assign write_reg   = main_entry.rd;
    assign immdata     = main_entry.imm;
    assign pc_out      = main_entry.pc;
    assign regwriteout = main_entry.regwrite;
    assign wbsel_out   = main_entry.wbsel;
    assign flush_count = flush_count_q;

    // Count flushes that actually threw something away (skid occupied
    // is visible as in_ready low); hold at all-ones.
    always_comb begin
        flush_count_d = flush_count_q;
        if (flush && (out_valid || !in_ready) && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    // Flush counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: hand-written vector table, stall/flush/reset
// sequences and randomized traffic against a queue-based model.
module tb_if_id_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] instrcode;
    logic [7:0] pc_in;
    logic       regwrite;
    logic       wbsel;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid, regwriteout, wbsel_out;
    logic [2:0] read_reg1, read_reg2, write_reg, immdata;
    logic [7:0] pc_out, flush_count;

    logic       s_in_ready, s_out_valid, s_regwriteout, s_wbsel_out;
    logic [2:0] s_read_reg1, s_read_reg2, s_write_reg;
    logic [7:0] s_immdata, s_pc_out, s_flush_count;

    logic       u_in_ready, u_out_valid, u_regwriteout, u_wbsel_out;
    logic [2:0] u_read_reg1, u_read_reg2, u_write_reg;
    logic [7:0] u_immdata, u_pc_out, u_flush_count;

    if_id_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instrcode(instrcode), .pc_in(pc_in), .regwrite(regwrite), .wbsel(wbsel),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .immdata(immdata), .regwriteout(regwriteout), .wbsel_out(wbsel_out),
        .pc_out(pc_out), .flush_count(flush_count)
    );

    if_id_pipe #(.IMM_SIGNED(1), .IMM_OUT_W(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .instrcode(instrcode), .pc_in(pc_in), .regwrite(regwrite), .wbsel(wbsel),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .read_reg1(s_read_reg1), .read_reg2(s_read_reg2), .write_reg(s_write_reg),
        .immdata(s_immdata), .regwriteout(s_regwriteout), .wbsel_out(s_wbsel_out),
        .pc_out(s_pc_out), .flush_count(s_flush_count)
    );

    if_id_pipe #(.IMM_SIGNED(0), .IMM_OUT_W(8)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .instrcode(instrcode), .pc_in(pc_in), .regwrite(regwrite), .wbsel(wbsel),
        .flush(flush), .out_valid(u_out_valid), .out_ready(out_ready),
        .read_reg1(u_read_reg1), .read_reg2(u_read_reg2), .write_reg(u_write_reg),
        .immdata(u_immdata), .regwriteout(u_regwriteout), .wbsel_out(u_wbsel_out),
        .pc_out(u_pc_out), .flush_count(u_flush_count)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: instructions held by the stage, oldest first, packed as
    // {regwrite, wbsel, pc, instr}. At most two can be held.
    logic [17:0] exp_q[$];
    logic [17:0] popped_q[$];
    int unsigned cnt_model = 0;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] pc;
        logic       rw;
        logic       wb;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [2:0] imm;
        logic [7:0] imm_s;
        logic [7:0] imm_u;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Three-bit immediate read as two's complement, widened to 8 bits.
    function automatic logic [7:0] imm_s8(input logic [7:0] instr);
        int v;
        v = int'(instr % 8);
        if (v >= 4) v = v - 8;
        return 8'(v);
    endfunction

    task automatic check_outputs();
        logic [17:0] e;
        logic [7:0]  ins;
        e   = (exp_q.size() > 0) ? exp_q[0] : 18'h0;
        ins = e[7:0];
        check("out_valid",   out_valid,   exp_q.size() > 0);
        check("in_ready",    in_ready,    exp_q.size() < 2);
        check("read_reg1",   read_reg1,   (ins / 8) % 8);
        check("read_reg2",   read_reg2,   ins % 8);
        check("write_reg",   write_reg,   (ins / 8) % 8);
        check("immdata",     immdata,     ins % 8);
        check("pc_out",      pc_out,      e[15:8]);
        check("regwriteout", regwriteout, e[17]);
        check("wbsel_out",   wbsel_out,   e[16]);
        check("flush_count", flush_count, cnt_model);
        check("s_out_valid", s_out_valid, exp_q.size() > 0);
        check("u_out_valid", u_out_valid, exp_q.size() > 0);
        check("immdata_s8",  s_immdata,   imm_s8(ins));
        check("immdata_u8",  u_immdata,   ins % 8);
    endtask

    // One clock: check outputs, drive inputs, advance, update the model.
    task automatic cycle(input logic v, input logic [7:0] ins, input logic [7:0] pc,
                         input logic rw, input logic wb, input logic fl,
                         input logic ordy, input logic r, output logic acc);
        logic inr, pp;
        check_outputs();
        in_valid  = v;
        instrcode = ins;
        pc_in     = pc;
        regwrite  = rw;
        wbsel     = wb;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        inr = exp_q.size() < 2;
        pp  = (exp_q.size() > 0) && ordy;
        acc = v && inr && !r && !fl;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            cnt_model = 0;
        end else if (fl) begin
            if (pp) popped_q.push_back(exp_q[0]);
            if (exp_q.size() > 0 && cnt_model < 255) cnt_model++;
            exp_q.delete();
        end else begin
            if (pp) popped_q.push_back(exp_q.pop_front());
            if (v && inr) exp_q.push_back({rw, wb, pc, ins});
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ordy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        logic [7:0] a, b, c;
        bit done;

        rst = 1'b1; in_valid = 1'b0; instrcode = '0; pc_in = '0;
        regwrite = 1'b0; wbsel = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Reset
        @(posedge clk); #1;
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

        // Vector table, back to back with out_ready high
        tbl[0] = '{8'b00_101_011, 8'h10, 1'b1, 1'b0, 3'd5, 3'd3, 3'd5, 3'd3, 8'h03, 8'h03};
        tbl[1] = '{8'b00_010_101, 8'h11, 1'b0, 1'b1, 3'd2, 3'd5, 3'd2, 3'd5, 8'hFD, 8'h05};
        tbl[2] = '{8'hFF,         8'h12, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 3'd7, 8'hFF, 8'h07};
        tbl[3] = '{8'h00,         8'hA0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00};
        tbl[4] = '{8'b11_100_110, 8'h3C, 1'b1, 1'b0, 3'd4, 3'd6, 3'd4, 3'd6, 8'hFE, 8'h06};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tbl[i].instr, tbl[i].pc, tbl[i].rw, tbl[i].wb, 1'b0, 1'b1, 1'b0, acc);
            check("tbl_valid", out_valid,   1'b1);
            check("tbl_rs1",   read_reg1,   tbl[i].rs1);
            check("tbl_rs2",   read_reg2,   tbl[i].rs2);
            check("tbl_rd",    write_reg,   tbl[i].rd);
            check("tbl_imm",   immdata,     tbl[i].imm);
            check("tbl_pc",    pc_out,      tbl[i].pc);
            check("tbl_rw",    regwriteout, tbl[i].rw);
            check("tbl_wb",    wbsel_out,   tbl[i].wb);
            check("tbl_imm_s", s_immdata,   tbl[i].imm_s);
            check("tbl_imm_u", u_immdata,   tbl[i].imm_u);
        end
        idle(1'b1);
        idle(1'b1);

        // Stall: A in main, B in skid, C refused until the stall lifts
        a = 8'h2B; b = 8'h15; c = 8'hE6;
        popped_q.delete();
        cycle(1'b1, a, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, b, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, c, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("stall_c_refused", acc, 1'b0);
        check("stall_in_ready", in_ready, 1'b0);
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            cycle(1'b1, c, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, acc);
            check("stall_no_gap", out_valid, 1'b1);
            done = acc;
        end
        if (!done) begin
            errors++;
            $display("FAIL stall_timeout actual=0 required=1");
        end
        for (int k = 0; k < 3; k++) idle(1'b1);
        check("order_count", popped_q.size(), 3);
        if (popped_q.size() == 3) begin
            check("order_a", popped_q[0][7:0], a);
            check("order_b", popped_q[1][7:0], b);
            check("order_c", popped_q[2][7:0], c);
        end

        // Flush with both entries full, input presented in the same cycle
        cycle(1'b1, 8'h11, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h22, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h33, 8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        check("flush_valid",   out_valid,   1'b0);
        check("flush_ready",   in_ready,    1'b1);
        check("flush_rw",      regwriteout, 1'b0);
        check("flush_count1",  flush_count, 8'd1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        check("flush_empty_count", flush_count, 8'd1);

        // Reset while the skid is full
        cycle(1'b1, 8'h44, 8'h50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h55, 8'h51, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("pre_rst_in_ready", in_ready, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_valid",    out_valid,   1'b0);
        check("rst_ready",    in_ready,    1'b1);
        check("rst_count",    flush_count, 8'd0);
        check("rst_pc",       pc_out,      8'h00);
        check("rst_rw",       regwriteout, 1'b0);
        idle(1'b1);

        // 300 flushes that each discard one entry
        for (int k = 0; k < 300; k++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        end
        check("sat_count", flush_count, 8'hFF);

        // Random traffic
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        for (int k = 0; k < 500; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 2) != 0), 1'b0, acc);
        end
        idle(1'b1);
        idle(1'b1);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
